ssd_mux_driver: RTL and testbench
=================================

SSD_MUX_DRIVER -- requirements
Module: ssd_mux_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of time-multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles each digit stays active; legal range >= 1.
REQ-003 Parameter HEX_EN, default 1: 1 = codes 10..15 render A,b,C,d,E,F; 0 = codes 10..15 render blank.
REQ-004 Port clk  input  1: single clock, all state on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port digits_in  input  4*N_DIGITS: nibble k is the value for digit k; digit 0 is least significant.
REQ-007 Port dp_in  input  N_DIGITS: decimal point request per digit, active-high.
REQ-008 Port blank_in  input  N_DIGITS: forced blank per digit, active-high.
REQ-009 Port load  input  1: high for one cycle captures digits_in, dp_in and blank_in into the holding registers.
REQ-010 Port lz_en  input  1: leading-zero suppression enable, sampled live every cycle.
REQ-011 Port seg_n  output  7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 Port dp_n  output  1: decimal point, active-low, registered.
REQ-013 Port an_n  output  N_DIGITS: digit anode enables, active-low, one-hot-low, registered.

Function
REQ-014 The block SHALL keep holding registers for digits, dp and blank; load=1 updates them on the same edge, and load=0 holds them.
REQ-015 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0. On the wrap edge, the digit index SHALL advance by 1, wrapping N_DIGITS-1 -> 0.
REQ-016 With REFRESH_DIV=1, the digit index SHALL advance every cycle.
REQ-017 Outputs SHALL be registered from the current index and the holding registers, giving one cycle of latency from an index or holding-register change to the pins.
REQ-018 an_n SHALL drive exactly bit [index] low and all other bits high whenever not in reset.
REQ-019 Active-high decode table (gfedcba):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- seg_n SHALL be the bitwise inverse of the table entry.
REQ-020 Blanked digits SHALL drive seg_n=1111111; outputs SHALL never be high-impedance.
REQ-021 A digit SHALL be blank when any of the following holds: blank bit set; code >= 10 with HEX_EN=0; or leading-zero suppressed.
REQ-022 Leading-zero suppression (lz_en=1): digit k SHALL be suppressed when its held value and the held values of all digits above k are 0. Digit 0 SHALL never be suppressed.
REQ-023 dp_n SHALL be the inverse of the held dp bit of the active digit. dp is independent of blanking.
REQ-024 When load and a counter wrap coincide, the next displayed digit SHALL use the newly loaded data.
REQ-025 A load mid-scan SHALL take effect from the next edge onward for whichever digit is active; no frame-level synchronisation is required.

Reset
REQ-026 While reset=1 on an edge:
- refresh counter=0, index=0, holding registers=0
- seg_n=1111111, dp_n=1, an_n all ones
REQ-027 On the first edge after reset deasserts, an_n[0]=0 and seg_n shows held digit 0, i.e. "0" = 1000000.
REQ-028 Reset asserted mid-scan SHALL override load and the counter on that edge.

Verification (N_DIGITS=4, REFRESH_DIV=4 unless noted)
REQ-029 Reset then load digits_in=0x1234, lz_en=0 -> an_n cycles 1110,1101,1011,0111 with 4 cycles each, wrapping. seg_n per digit: 4=0011001, 3=0110000, 2=0100100, 1=1111001.
REQ-030 Load 0x00A0 with HEX_EN=1, lz_en=1 -> digits 3 and 2 blank (1111111), digit 1 = 0001000, digit 0 = 1000000. The same load with HEX_EN=0 -> digit 1 blank.
REQ-031 Load 0x0000 with lz_en=1 -> digits 3..1 blank and digit 0 shows 1000000. Then dp_in=0100 -> dp_n=0 only while an_n=1011.
REQ-032 Assert load on a counter-wrap edge (0x1111 -> 0x9999) -> the digit that becomes active shows 0010000 on the following cycle, with no stale 1111001.
REQ-033 Assert reset while index=2, mid-count -> on the next edge all outputs take reset values. After release, an_n=1110 and the counter restarts from 0.
REQ-034 REFRESH_DIV=1, N_DIGITS=1 -> an_n stays 0 permanently and seg_n follows each load with 1-cycle latency.

Source files
------------

// File: rtl/ssd_mux_driver.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// ssd_mux_driver
//
// Time-multiplexed seven-segment display driver. A set of holding registers
// keeps the value, decimal point and blank request for every digit. A refresh
// counter walks the active digit index through 0..N_DIGITS-1, spending
// REFRESH_DIV clock cycles on each digit. The segment, decimal-point and anode
// pins are registered from the current index and the holding registers, so
// they change one cycle after either of those changes.
//
// Parameters
//   N_DIGITS     number of multiplexed digits (1..8)
//   REFRESH_DIV  clock cycles each digit stays active (>= 1)
//   HEX_EN       1: codes 10..15 render A,b,C,d,E,F   0: codes 10..15 blank
//
// Ports
//   clk        in   single clock, all state on the rising edge
//   reset      in   synchronous, active-high reset
//   digits_in  in   nibble k is the value for digit k (digit 0 = least significant)
//   dp_in      in   decimal point request per digit, active-high
//   blank_in   in   forced blank per digit, active-high
//   load       in   one-cycle strobe capturing digits_in / dp_in / blank_in
//   lz_en      in   leading-zero suppression enable, used live every cycle
//   seg_n      out  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n       out  decimal point, active-low, registered
//   an_n       out  digit anode enables, active-low one-hot, registered
// -----------------------------------------------------------------------------
module ssd_mux_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n
);

  // ---------------------------------------------------------------------------
  // Widths and terminal values. Both counters keep at least one bit so the
  // degenerate REFRESH_DIV=1 / N_DIGITS=1 builds still elaborate cleanly.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  localparam logic [6:0] SEG_OFF_N = 7'b111_1111;

  // ---------------------------------------------------------------------------
  // Active-high glyph table, bit order {g,f,e,d,c,b,a}.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b011_1111;
      4'h1:    seg = 7'b000_0110;
      4'h2:    seg = 7'b101_1011;
      4'h3:    seg = 7'b100_1111;
      4'h4:    seg = 7'b110_0110;
      4'h5:    seg = 7'b110_1101;
      4'h6:    seg = 7'b111_1101;
      4'h7:    seg = 7'b000_0111;
      4'h8:    seg = 7'b111_1111;
      4'h9:    seg = 7'b110_1111;
      4'hA:    seg = 7'b111_0111;
      4'hB:    seg = 7'b111_1100;
      4'hC:    seg = 7'b011_1001;
      4'hD:    seg = 7'b101_1110;
      4'hE:    seg = 7'b111_1001;
      default: seg = 7'b111_0001; // F
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [4*N_DIGITS-1:0] dig_q,     dig_d;
  logic [N_DIGITS-1:0]   dp_q,      dp_d;
  logic [N_DIGITS-1:0]   blank_q,   blank_d;
  logic [6:0]            seg_n_q,   seg_n_d;
  logic                  dp_n_q,    dp_n_d;
  logic [N_DIGITS-1:0]   an_n_q,    an_n_d;

  // Combinational helpers
  logic                  wrap;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   lz_mask;
  logic [3:0]            act_code;
  logic                  act_dp;
  logic                  act_blank;
  logic                  act_lz;
  logic                  act_hex_off;
  logic                  act_off;

  // ---------------------------------------------------------------------------
  // Refresh counter, digit index and holding registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    dp_d    = dp_q;
    blank_d = blank_q;

    wrap = (cnt_q == CNT_MAX);

    if (wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A load on a wrap edge lands together with the index advance, so the
    // next digit is rendered from the new data on the following edge.
    if (load) begin
      dig_d   = digits_in;
      dp_d    = dp_in;
      blank_d = blank_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask: digit k is suppressed when it and every digit above it
  // hold zero. The scan stops at k=1, so digit 0 is never suppressed and an
  // all-zero value still shows a single "0".
  // ---------------------------------------------------------------------------
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (dig_q[4*k +: 4] == 4'd0);
      lz_mask[k] = lz_en & zero_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Select the active digit's held data. A compare-per-digit mux avoids
  // indexing past N_DIGITS when N_DIGITS is not a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    act_code  = 4'd0;
    act_dp    = 1'b0;
    act_blank = 1'b0;
    act_lz    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        act_code  = dig_q[4*k +: 4];
        act_dp    = dp_q[k];
        act_blank = blank_q[k];
        act_lz    = lz_mask[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pin next-state. The decimal point ignores blanking on purpose so a blanked
  // position can still carry a separator dot.
  // ---------------------------------------------------------------------------
  always_comb begin
    act_hex_off = (HEX_EN == 0) && (act_code >= 4'd10);
    act_off     = act_blank | act_lz | act_hex_off;

    seg_n_d = act_off ? SEG_OFF_N : ~seg_decode(act_code);
    dp_n_d  = ~act_dp;

    an_n_d = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      an_n_d[k] = (idx_q != IDX_W'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset wins over load and over the counter on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      // NOTE: the holding registers are plain flops, not a RAM, so clearing
      // them in reset costs nothing and makes the first frame deterministic.
      dig_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_n_q <= SEG_OFF_N;
      dp_n_q  <= 1'b1;
      an_n_q  <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_ssd_mux_driver
//
// Three instances share one clock and reset:
//   u_hex  N_DIGITS=4, REFRESH_DIV=4, HEX_EN=1
//   u_dec  N_DIGITS=4, REFRESH_DIV=4, HEX_EN=0 (same inputs as u_hex)
//   u_one  N_DIGITS=1, REFRESH_DIV=1, HEX_EN=1 (own inputs)
// Inputs are driven and outputs sampled 1 ns after each rising edge. The
// variable cyc counts edges since reset release (0 = first edge), so the
// displayed index of the 4-digit instances after edge cyc is (cyc/4)%4.
// -----------------------------------------------------------------------------
module tb_ssd_mux_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic        lz_en;

  logic [6:0]  hex_seg_n, dec_seg_n;
  logic        hex_dp_n,  dec_dp_n;
  logic [3:0]  hex_an_n,  dec_an_n;

  logic [3:0]  one_digits;
  logic        one_dp, one_blank, one_load, one_lz;
  logic [6:0]  one_seg_n;
  logic        one_dp_n;
  logic [0:0]  one_an_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ssd_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1)) u_hex (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .lz_en(lz_en),
    .seg_n(hex_seg_n), .dp_n(hex_dp_n), .an_n(hex_an_n)
  );

  ssd_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0)) u_dec (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .lz_en(lz_en),
    .seg_n(dec_seg_n), .dp_n(dec_dp_n), .an_n(dec_an_n)
  );

  ssd_mux_driver #(.N_DIGITS(1), .REFRESH_DIV(1), .HEX_EN(1)) u_one (
    .clk(clk), .reset(reset), .digits_in(one_digits), .dp_in(one_dp),
    .blank_in(one_blank), .load(one_load), .lz_en(one_lz),
    .seg_n(one_seg_n), .dp_n(one_dp_n), .an_n(one_an_n)
  );

  localparam logic [6:0] S_OFF = 7'b111_1111;
  localparam logic [6:0] S_0   = 7'b100_0000;
  localparam logic [6:0] S_1   = 7'b111_1001;
  localparam logic [6:0] S_2   = 7'b010_0100;
  localparam logic [6:0] S_3   = 7'b011_0000;
  localparam logic [6:0] S_4   = 7'b001_1001;
  localparam logic [6:0] S_5   = 7'b001_0010;
  localparam logic [6:0] S_7   = 7'b111_1000;
  localparam logic [6:0] S_9   = 7'b001_0000;
  localparam logic [6:0] S_A   = 7'b000_1000;
  localparam logic [6:0] S_E   = 7'b000_0110;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] an_for(input int i);
    logic [3:0] r;
    r    = 4'b1111;
    r[i] = 1'b0;
    return r;
  endfunction

  function automatic int cur_idx();
    return (cyc / 4) % 4;
  endfunction

  // Reset values on all instances, then the first edge after release.
  task automatic test_reset();
    reset = 1'b1; load = 1'b0; digits_in = 16'h0000; dp_in = '0;
    blank_in = '0; lz_en = 1'b0;
    one_digits = 4'h0; one_dp = 1'b0; one_blank = 1'b0; one_load = 1'b0;
    one_lz = 1'b0;
    tick(); tick();
    checks++;
    if (hex_seg_n !== S_OFF || hex_dp_n !== 1'b1 || hex_an_n !== 4'b1111) begin
      errors++;
      $display("FAIL reset_hex got seg=%b dp=%b an=%b exp seg=%b dp=1 an=1111",
               hex_seg_n, hex_dp_n, hex_an_n, S_OFF);
    end
    checks++;
    if (one_seg_n !== S_OFF || one_dp_n !== 1'b1 || one_an_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_one got seg=%b dp=%b an=%b exp seg=%b dp=1 an=1",
               one_seg_n, one_dp_n, one_an_n, S_OFF);
    end
    reset = 1'b0;
    cyc   = -1;
    tick();
    checks++;
    if (hex_an_n !== 4'b1110 || hex_seg_n !== S_0 || hex_dp_n !== 1'b1) begin
      errors++;
      $display("FAIL first_edge got seg=%b dp=%b an=%b exp seg=%b dp=1 an=1110",
               hex_seg_n, hex_dp_n, hex_an_n, S_0);
    end
  endtask

  // 0x1234, no suppression: two full frames of scan order and glyphs.
  task automatic test_scan();
    logic [6:0] tbl [4];
    tbl[0] = S_4; tbl[1] = S_3; tbl[2] = S_2; tbl[3] = S_1;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b0;
    load = 1'b1; tick(); load = 1'b0;
    for (int n = 0; n < 32; n++) begin
      tick();
      checks++;
      if (hex_an_n !== an_for(cur_idx()) || hex_seg_n !== tbl[cur_idx()] ||
          hex_dp_n !== 1'b1) begin
        errors++;
        $display("FAIL scan_1234 cyc=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=1",
                 cyc, hex_an_n, hex_seg_n, hex_dp_n, an_for(cur_idx()), tbl[cur_idx()]);
      end
    end
  endtask

  // Forced blank on digit 1 while its decimal point stays lit.
  task automatic test_blank_dp();
    logic [6:0] tbl [4];
    tbl[0] = S_4; tbl[1] = S_OFF; tbl[2] = S_2; tbl[3] = S_1;
    digits_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'b0010; lz_en = 1'b0;
    load = 1'b1; tick(); load = 1'b0;
    for (int n = 0; n < 16; n++) begin
      tick();
      checks++;
      if (hex_seg_n !== tbl[cur_idx()] || hex_dp_n !== (cur_idx() != 1)) begin
        errors++;
        $display("FAIL blank_dp cyc=%0d got seg=%b dp=%b exp seg=%b dp=%b",
                 cyc, hex_seg_n, hex_dp_n, tbl[cur_idx()], (cur_idx() != 1));
      end
    end
  endtask

  // 0x00A0 with suppression, on the hex and the decimal-only instance.
  task automatic test_lz_hex();
    logic [6:0] hex_tbl [4];
    logic [6:0] dec_tbl [4];
    hex_tbl[0] = S_0; hex_tbl[1] = S_A;   hex_tbl[2] = S_OFF; hex_tbl[3] = S_OFF;
    dec_tbl[0] = S_0; dec_tbl[1] = S_OFF; dec_tbl[2] = S_OFF; dec_tbl[3] = S_OFF;
    digits_in = 16'h00A0; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b1;
    load = 1'b1; tick(); load = 1'b0;
    for (int n = 0; n < 16; n++) begin
      tick();
      checks++;
      if (hex_seg_n !== hex_tbl[cur_idx()]) begin
        errors++;
        $display("FAIL lz_hex cyc=%0d got seg=%b exp seg=%b",
                 cyc, hex_seg_n, hex_tbl[cur_idx()]);
      end
      checks++;
      if (dec_seg_n !== dec_tbl[cur_idx()] || dec_an_n !== an_for(cur_idx())) begin
        errors++;
        $display("FAIL lz_nohex cyc=%0d got seg=%b an=%b exp seg=%b an=%b",
                 cyc, dec_seg_n, dec_an_n, dec_tbl[cur_idx()], an_for(cur_idx()));
      end
    end
  endtask

  // All-zero value: only digit 0 shows; dp on digit 2. Then drop lz_en live.
  task automatic test_zero_dp();
    digits_in = 16'h0000; dp_in = 4'b0100; blank_in = 4'b0000; lz_en = 1'b1;
    load = 1'b1; tick(); load = 1'b0;
    for (int n = 0; n < 16; n++) begin
      tick();
      checks++;
      if (hex_seg_n !== ((cur_idx() == 0) ? S_0 : S_OFF) ||
          hex_dp_n !== (cur_idx() != 2)) begin
        errors++;
        $display("FAIL zero_dp cyc=%0d got seg=%b dp=%b exp seg=%b dp=%b",
                 cyc, hex_seg_n, hex_dp_n, (cur_idx() == 0) ? S_0 : S_OFF,
                 (cur_idx() != 2));
      end
    end
    lz_en = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (hex_seg_n !== S_0) begin
        errors++;
        $display("FAIL lz_live_off cyc=%0d got seg=%b exp seg=%b", cyc, hex_seg_n, S_0);
      end
    end
  endtask

  // Load landing exactly on a counter-wrap edge.
  task automatic test_load_on_wrap();
    digits_in = 16'h1111; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b0;
    load = 1'b1; tick(); load = 1'b0;
    // Edge m wraps when m%4 == 3; step until the next edge is such an edge.
    for (int n = 0; n < 4 && ((cyc + 1) % 4 != 3); n++) tick();
    digits_in = 16'h9999; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (hex_seg_n !== S_1) begin
      errors++;
      $display("FAIL wrap_edge cyc=%0d got seg=%b exp seg=%b", cyc, hex_seg_n, S_1);
    end
    tick();
    checks++;
    if (hex_seg_n !== S_9 || hex_an_n !== an_for(cur_idx()) || (cyc % 4) != 0) begin
      errors++;
      $display("FAIL wrap_new_digit cyc=%0d got seg=%b an=%b exp seg=%b an=%b",
               cyc, hex_seg_n, hex_an_n, S_9, an_for(cur_idx()));
    end
  endtask

  // Reset while index 2 is mid-count, with a competing load on the same edge.
  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      // internal index after edge cyc is ((cyc+1)/4)%4, counter is (cyc+1)%4
      if ((((cyc + 1) / 4) % 4) == 2 && ((cyc + 1) % 4) == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_timeout got no index-2 mid-count point exp one within 20 cycles");
    end
    reset = 1'b1; load = 1'b1; digits_in = 16'h8888; dp_in = 4'b1111; lz_en = 1'b0;
    tick();
    checks++;
    if (hex_seg_n !== S_OFF || hex_dp_n !== 1'b1 || hex_an_n !== 4'b1111) begin
      errors++;
      $display("FAIL reset_mid got seg=%b dp=%b an=%b exp seg=%b dp=1 an=1111",
               hex_seg_n, hex_dp_n, hex_an_n, S_OFF);
    end
    reset = 1'b0; load = 1'b0;
    cyc = -1;
    tick();
    checks++;
    if (hex_an_n !== 4'b1110 || hex_seg_n !== S_0 || hex_dp_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got seg=%b dp=%b an=%b exp seg=%b dp=1 an=1110",
               hex_seg_n, hex_dp_n, hex_an_n, S_0);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (hex_an_n !== 4'b1110) begin
        errors++;
        $display("FAIL restart_hold cyc=%0d got an=%b exp an=1110", cyc, hex_an_n);
      end
    end
    tick();
    checks++;
    if (hex_an_n !== 4'b1101) begin
      errors++;
      $display("FAIL restart_advance cyc=%0d got an=%b exp an=1101", cyc, hex_an_n);
    end
  endtask

  // Single digit, REFRESH_DIV=1: loads every cycle, one-cycle latency.
  task automatic test_div1();
    logic [3:0] vals  [5];
    logic       dps   [5];
    logic       blks  [5];
    logic [6:0] segs  [5];
    vals[0] = 4'h3; dps[0] = 1'b1; blks[0] = 1'b0; segs[0] = S_3;
    vals[1] = 4'h7; dps[1] = 1'b0; blks[1] = 1'b0; segs[1] = S_7;
    vals[2] = 4'hE; dps[2] = 1'b1; blks[2] = 1'b0; segs[2] = S_E;
    vals[3] = 4'h0; dps[3] = 1'b0; blks[3] = 1'b0; segs[3] = S_0;
    vals[4] = 4'h5; dps[4] = 1'b1; blks[4] = 1'b1; segs[4] = S_OFF;
    one_lz = 1'b1; one_load = 1'b1;
    for (int j = 0; j < 5; j++) begin
      one_digits = vals[j]; one_dp = dps[j]; one_blank = blks[j];
      tick();
      if (j > 0) begin
        checks++;
        if (one_seg_n !== segs[j-1] || one_dp_n !== ~dps[j-1] || one_an_n !== 1'b0) begin
          errors++;
          $display("FAIL div1_load%0d got seg=%b dp=%b an=%b exp seg=%b dp=%b an=0",
                   j - 1, one_seg_n, one_dp_n, one_an_n, segs[j-1], ~dps[j-1]);
        end
      end
    end
    one_load = 1'b0; one_digits = 4'h8; one_blank = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (one_seg_n !== S_OFF || one_dp_n !== 1'b0 || one_an_n !== 1'b0) begin
        errors++;
        $display("FAIL div1_hold%0d got seg=%b dp=%b an=%b exp seg=%b dp=0 an=0",
                 n, one_seg_n, one_dp_n, one_an_n, S_OFF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_dp();
    test_lz_hex();
    test_zero_dp();
    test_load_on_wrap();
    test_reset_mid();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got time limit reached exp bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
